gc_write_arbiter: RTL

//  Shares the gain-curve RAM write port (gcurve) and the display-curve RAM write port (gcdisp)

---
 rtl/gc_write_arbiter.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/gc_write_arbiter.sv
// gc_write_arbiter
//   Shares the gain-curve RAM write port (gcurve) and the display-curve RAM
//   write port (gcdisp) among three requesters:
//     0 = curve-reset engine, 1 = band-edit engine, 2 = host loader.
//   A grant is locked to its owner until the owner drops req. Every owner
//   change is separated by at least one dead cycle with no writes.
//
//   Ports
//     clk, rst_n                 clock, asynchronous active-low reset
//     req[2:0]                   per-requester request (held for the burst)
//     gnt[2:0]                   registered one-hot grant
//     rq_we[2:0]                 per-requester write strobe
//     rq_gcurve_addr/din         flattened requester gcurve buses
//     rq_gcdisp_addr/din         flattened requester gcdisp buses
//     gcurve_addr/din/we         registered gcurve write port
//     gcdisp_addr/din/we         registered gcdisp write port
//     busy                       any grant held
//     drop_cnt                   saturating count of cycles with ungranted writes
//
//   Build option
//     GC_ARB_RR_EN : requester 0 keeps absolute priority, requesters 1 and 2
//                    share the remaining priority round-robin. Undefined gives
//                    strict priority 0 > 1 > 2.
//
//   state | meaning
//   ------+---------------------------------------------------
//   IDLE  | no owner; arbitrate on any req
//   OWN   | grant held by one requester while its req stays high
//   GAP   | one dead cycle after a release, no grant, no writes

module gc_write_arbiter #(
    parameter int LOGFFTSIZE = 13,
    parameter int AUDIOWIDTH = 16,
    parameter int DISPLWIDTH = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [2:0]              req,
    output logic [2:0]              gnt,
    input  logic [2:0]              rq_we,
    input  logic [3*LOGFFTSIZE-1:0] rq_gcurve_addr,
    input  logic [3*AUDIOWIDTH-1:0] rq_gcurve_din,
    input  logic [3*10-1:0]         rq_gcdisp_addr,
    input  logic [3*DISPLWIDTH-1:0] rq_gcdisp_din,
    output logic [LOGFFTSIZE-1:0]   gcurve_addr,
    output logic [AUDIOWIDTH-1:0]   gcurve_din,
    output logic                    gcurve_we,
    output logic [9:0]              gcdisp_addr,
    output logic [DISPLWIDTH-1:0]   gcdisp_din,
    output logic                    gcdisp_we,
    output logic                    busy,
    output logic [7:0]              drop_cnt
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OWN  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [2:0] gnt_d;
    logic [2:0] win;
    logic       owner_release;

    // Owner is released as soon as its own req is sampled low.
    assign owner_release = ~|(gnt & req);

`ifdef GC_ARB_RR_EN
    // rr_ptr_q = 0 favours requester 1, 1 favours requester 2.
    logic rr_ptr_q;

    always_comb begin
        win = 3'b000;
        if (req[0])
            win = 3'b001;
        else if (req[1] && req[2])
            win = rr_ptr_q ? 3'b100 : 3'b010;
        else if (req[1])
            win = 3'b010;
        else if (req[2])
            win = 3'b100;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            rr_ptr_q <= 1'b0;
        else if (state_q == S_IDLE && (win[1] || win[2]))
            rr_ptr_q <= win[1];
    end
`else
    always_comb begin
        win = 3'b000;
        if (req[0])
            win = 3'b001;
        else if (req[1])
            win = 3'b010;
        else if (req[2])
            win = 3'b100;
    end
`endif

    // State register (grant is registered alongside it)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            gnt     <= 3'b000;
        end else begin
            state_q <= state_d;
            gnt     <= gnt_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (|req) state_d = S_OWN;
            S_OWN:   if (owner_release) state_d = S_GAP;
            S_GAP:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output logic: next grant value
    always_comb begin
        gnt_d = gnt;
        case (state_q)
            S_IDLE:  gnt_d = win;
            S_OWN:   if (owner_release) gnt_d = 3'b000;
            S_GAP:   gnt_d = 3'b000;
            default: gnt_d = 3'b000;
        endcase
    end

    assign busy = |gnt;

    // Write acceptance and owner bus select
    logic [2:0]            acc_vec;
    logic                  wr_acc;
    logic                  drop_any;
    logic [LOGFFTSIZE-1:0] sel_gaddr;
    logic [AUDIOWIDTH-1:0] sel_gdin;
    logic [9:0]            sel_daddr;
    logic [DISPLWIDTH-1:0] sel_ddin;

    assign acc_vec  = gnt & req & rq_we;
    assign wr_acc   = |acc_vec;
    assign drop_any = |(rq_we & ~gnt);

    always_comb begin
        sel_gaddr = '0;
        sel_gdin  = '0;
        sel_daddr = '0;
        sel_ddin  = '0;
        for (int r = 0; r < 3; r++) begin
            if (acc_vec[r]) begin
                sel_gaddr = rq_gcurve_addr[r*LOGFFTSIZE +: LOGFFTSIZE];
                sel_gdin  = rq_gcurve_din[r*AUDIOWIDTH +: AUDIOWIDTH];
                sel_daddr = rq_gcdisp_addr[r*10 +: 10];
                sel_ddin  = rq_gcdisp_din[r*DISPLWIDTH +: DISPLWIDTH];
            end
        end
    end

    // Address/data hold their last value when no write is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gcurve_addr <= '0;
            gcurve_din  <= '0;
            gcurve_we   <= 1'b0;
            gcdisp_addr <= '0;
            gcdisp_din  <= '0;
            gcdisp_we   <= 1'b0;
            drop_cnt    <= 8'd0;
        end else begin
            gcurve_we <= wr_acc;
            gcdisp_we <= wr_acc;
            if (wr_acc) begin
                gcurve_addr <= sel_gaddr;
                gcurve_din  <= sel_gdin;
                gcdisp_addr <= sel_daddr;
                gcdisp_din  <= sel_ddin;
            end
            if (drop_any && drop_cnt != 8'hFF)
                drop_cnt <= drop_cnt + 8'd1;
        end
    end

endmodule
